// File: rtl/residue7_serial_arbiter_if.sv
// Handshake bundle for the shared serial mod-7 residue engine:
// two operand requesters and one result channel.
interface residue7_serial_arbiter_if #(
    parameter int NUM_OF_BITS = 48
);
    logic                   req0_valid;
    logic [NUM_OF_BITS-1:0] req0_data;
    logic                   req0_ready;
    logic                   req1_valid;
    logic [NUM_OF_BITS-1:0] req1_data;
    logic                   req1_ready;
    logic                   res_valid;
    logic [2:0]             res_data;
    logic                   res_id;
    logic                   res_ready;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, res_ready,
        input  req0_ready, req1_ready, res_valid, res_data, res_id
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
        output req0_ready, req1_ready, res_valid, res_data, res_id
    );
endinterface

// File: rtl/residue7_serial_arbiter.sv
// Serial mod-7 residue engine shared by two requesters.
// One 3-bit digit is folded per cycle through a single mod-7 adder (8 == 1 mod 7).
// Optional feature macro: RES7_EARLY_DONE_EN -- finish as soon as the remaining
// operand bits are all zero instead of always running DIGITS fold cycles.
//
// state | meaning
// IDLE  | arbitrate between requesters, accept one operand
// RUN   | fold one digit per cycle into the accumulator
// DONE  | hold the residue on the result channel until consumed
module residue7_serial_arbiter #(
    parameter int NUM_OF_BITS = 48
) (
    input logic                      clk,
    input logic                      rst,
    residue7_serial_arbiter_if.slave bus
);
    localparam int DIGITS = NUM_OF_BITS / 3;
    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [NUM_OF_BITS-1:0] shreg;
    logic [NUM_OF_BITS-1:0] shreg_shift;
    logic [2:0]             acc;
    logic [CNT_W-1:0]       cnt;
    logic                   id;
    logic                   last_grant;
    logic                   grant;
    logic                   accept;
    logic                   fold_last;
    logic                   req0_ready;
    logic                   req1_ready;
    logic                   res_valid;
    logic [2:0]             res_data;
    logic                   res_id;

    function automatic logic [2:0] mod7add(input logic [2:0] x, input logic [2:0] y);
        logic [3:0] s;
        logic [3:0] t;
        s = {1'b0, x} + {1'b0, y};
        t = s - 4'd7;
        return (s >= 4'd7) ? t[2:0] : s[2:0];
    endfunction

    assign shreg_shift = shreg >> 3;

`ifdef RES7_EARLY_DONE_EN
    assign fold_last = (cnt == CNT_LAST) || (shreg_shift == '0);
`else
    assign fold_last = (cnt == CNT_LAST);
`endif

    // Tie goes to whoever did not win last time; a lone requester always wins.
    always_comb begin
        grant = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; readies depend only on state, valids, last_grant.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        res_valid  = 1'b0;
        res_data   = 3'd0;
        res_id     = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = bus.req0_valid && !grant;
                req1_ready = bus.req1_valid && grant;
                accept     = req0_ready || req1_ready;
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (fold_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                res_data  = acc;
                res_id    = id;
                if (bus.res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept, then one digit folded per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            acc        <= 3'd0;
            cnt        <= '0;
            id         <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg      <= grant ? bus.req1_data : bus.req0_data;
                        acc        <= 3'd0;
                        cnt        <= '0;
                        id         <= grant;
                        last_grant <= grant;
                    end
                end
                RUN: begin
                    acc   <= mod7add(acc, shreg[2:0]);
                    shreg <= shreg_shift;
                    cnt   <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = req0_ready;
    assign bus.req1_ready = req1_ready;
    assign bus.res_valid  = res_valid;
    assign bus.res_data   = res_data;
    assign bus.res_id     = res_id;
endmodule

// File: tb/tb_residue7_serial_arbiter.sv
// Scoreboard bench for residue7_serial_arbiter: drivers issue operands, a
// negedge monitor predicts grants, residues and latency from plain arithmetic.
module tb_residue7_serial_arbiter;
    localparam int NB     = 48;
    localparam int DIGITS = NB / 3;

    typedef struct {
        logic       id;
        logic [2:0] res;
        int         acc_cyc;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    residue7_serial_arbiter_if #(.NUM_OF_BITS(NB)) bus ();

    residue7_serial_arbiter #(.NUM_OF_BITS(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   busy = 1'b0;
    logic last_grant = 1'b1;
    bit   prev_valid = 1'b0;
    bit   prev_rst = 1'b0;
    bit   stop_rr = 1'b0;

    function automatic logic [2:0] ref_res(input logic [NB-1:0] d);
        logic [63:0] t;
        t = 64'(d) % 64'd7;
        return t[2:0];
    endfunction

    function automatic int ref_lat(input logic [NB-1:0] d);
`ifdef RES7_EARLY_DONE_EN
        int hi;
        hi = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (((d >> (3 * i)) & 48'd7) != 0) hi = i;
        end
        return hi + 1;
`else
        return (d == d) ? DIGITS : DIGITS;
`endif
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare DUT against the reference, then advance the reference.
    always @(negedge clk) begin : monitor
        logic e0, e1;
        logic [NB-1:0] d;
        if (prev_rst && !rst) begin
            check("post_reset_res_valid", bus.res_valid, 0);
            check("post_reset_res_data", bus.res_data, 0);
            check("post_reset_res_id", bus.res_id, 0);
        end
        e0 = !busy && bus.req0_valid && (!bus.req1_valid || last_grant);
        e1 = !busy && bus.req1_valid && (!bus.req0_valid || !last_grant);
        check("req0_ready", bus.req0_ready, e0);
        check("req1_ready", bus.req1_ready, e1);
        if (bus.res_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_res_valid", 1, 0);
            end else begin
                check("res_data", bus.res_data, exp_q[0].res);
                check("res_id", bus.res_id, exp_q[0].id);
                if (!prev_valid) check("latency", cyc - exp_q[0].acc_cyc, exp_q[0].lat);
            end
        end
        prev_valid = bus.res_valid;
        prev_rst   = rst;
        if (rst) begin
            exp_q.delete();
            busy       = 1'b0;
            last_grant = 1'b1;
        end else begin
            if (bus.res_valid && bus.res_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                busy = 1'b0;
            end
            if (e0 || e1) begin
                d = e1 ? bus.req1_data : bus.req0_data;
                exp_q.push_back('{id: e1, res: ref_res(d), acc_cyc: cyc + 1, lat: ref_lat(d)});
                busy       = 1'b1;
                last_grant = e1;
            end
        end
    end

    // Present one operand and wait for its handshake; keep leaves valid high.
    task automatic send(input int r, input logic [NB-1:0] d, input bit keep);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        if (r == 0) begin
            bus.req0_valid = 1'b1;
            bus.req0_data  = d;
        end else begin
            bus.req1_valid = 1'b1;
            bus.req1_data  = d;
        end
        while (!done) begin
            @(negedge clk);
            if ((r == 0 && bus.req0_ready) || (r == 1 && bus.req1_ready)) begin
                done = 1'b1;
            end else if (++n > 300) begin
                check("handshake_timeout", n, 0);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            if (r == 0) bus.req0_valid = 1'b0;
            else        bus.req1_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_timeout", (n >= 500) ? 1 : 0, 0);
    endtask

    function automatic logic [NB-1:0] rand_operand();
        logic [63:0] w;
        w = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
            0:       return NB'($urandom_range(0, 7));
            1:       return w[NB-1:0];
            2:       return w[NB-1:0] >> $urandom_range(0, NB - 1);
            default: return {NB{1'b1}};
        endcase
    endfunction

    task automatic rand_driver(input int r, input int count);
        for (int k = 0; k < count; k++) begin
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
            send(r, rand_operand(), 1'b0);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        bus.req0_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;
        bus.res_ready  = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed single-requester operands.
        send(0, 48'd100, 1'b0);            drain();
        send(0, 48'd1000000, 1'b0);        drain();
        send(0, 48'hFFFF_FFFF_FFFF, 1'b0); drain();
        send(0, 48'd6, 1'b0);              drain();
        send(0, 48'd5, 1'b0);              drain();
        send(0, 48'd0, 1'b0);              drain();
        send(0, 48'h8000_0000_0000, 1'b0); drain();

        // Both requesters continuously valid: grants must alternate.
        fork
            begin send(0, 48'd5, 1'b1); send(0, 48'd5, 1'b0); end
            begin send(1, 48'd9, 1'b1); send(1, 48'd9, 1'b0); end
        join
        drain();

        // Consumer stalls: result must hold and no operand may be accepted.
        bus.res_ready = 1'b0;
        send(0, 48'd123456789, 1'b0);
        n = 0;
        while (!bus.res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stall_res_valid_timeout", (n >= 100) ? 1 : 0, 0);
        @(posedge clk);
        #1;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 48'd4242;
        repeat (5) @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        send(1, 48'd4242, 1'b0);
        drain();

        // Reset in the middle of a fold, then a fresh tie goes to requester 0.
        send(0, 48'd100, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        fork
            send(0, 48'd100, 1'b0);
            send(1, 48'd77, 1'b0);
        join
        drain();

        // Randomized traffic with a randomly stalling consumer.
        stop_rr = 1'b0;
        fork
            begin
                fork
                    rand_driver(0, 25);
                    rand_driver(1, 25);
                join
                stop_rr = 1'b1;
            end
            begin
                while (!stop_rr) begin
                    @(posedge clk);
                    #1;
                    bus.res_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.res_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
